// File: rtl/fetch_buffered.sv
// rtl/fetch_buffered.sv - RV32 fetch stage: one-outstanding I-cache requests, JAL/BHT predecode, decoupling queue
module fetch_buffered #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FQ_DEPTH    = 4,
  parameter int          BHT_ENTRIES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_resp_valid,
  input  logic [31:0] ic_resp_data,
  input  logic        bp_we,
  input  logic [31:0] bp_w_pc,
  input  logic        bp_taken,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_p4,
  output logic        out_pred_taken,
  output logic [31:0] out_pred_target
);
  localparam int IW = $clog2(BHT_ENTRIES);
  localparam int PW = $clog2(FQ_DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          inflight_q, drop_q;
  logic [CW-1:0] cnt_q;
  logic [PW-1:0] wr_q, rd_q;
  logic [31:0]   q_instr [FQ_DEPTH];
  logic [31:0]   q_pc    [FQ_DEPTH];
  logic          q_tk    [FQ_DEPTH];
  logic [31:0]   q_tgt   [FQ_DEPTH];
  logic [1:0]    bht_q   [BHT_ENTRIES];

  logic          resp_fire, push, pop, accept;
  logic          is_jal, is_br, pred_tk;
  logic [31:0]   imm_j, imm_b, pred_tgt;
  logic [IW-1:0] rd_idx, wr_idx;

  assign resp_fire = ic_resp_valid && inflight_q;
  assign push      = resp_fire && !drop_q && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign ic_req_valid = rst_n && !inflight_q && (cnt_q < CW'(FQ_DEPTH)) && !redirect;
  assign ic_req_addr  = fetch_pc_q;
  assign accept       = ic_req_valid && ic_req_ready;

  // Predecode of the returned word; the BHT read sees the pre-update counter
  assign is_jal   = ic_resp_data[6:0] == 7'b1101111;
  assign is_br    = ic_resp_data[6:0] == 7'b1100011;
  assign imm_j    = {{11{ic_resp_data[31]}}, ic_resp_data[31], ic_resp_data[19:12],
                     ic_resp_data[20], ic_resp_data[30:21], 1'b0};
  assign imm_b    = {{19{ic_resp_data[31]}}, ic_resp_data[31], ic_resp_data[7],
                     ic_resp_data[30:25], ic_resp_data[11:8], 1'b0};
  assign rd_idx   = fetch_pc_q[IW+1:2];
  assign wr_idx   = bp_w_pc[IW+1:2];
  assign pred_tk  = is_jal || (is_br && bht_q[rd_idx][1]);
  assign pred_tgt = fetch_pc_q + (is_jal ? imm_j : imm_b);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = pred_tk ? pred_tgt : fetch_pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      if (redirect) begin
        cnt_q <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
        if (resp_fire) begin
          inflight_q <= 1'b0;
          drop_q     <= 1'b0;
        end else if (inflight_q) begin
          drop_q <= 1'b1;
        end
      end else begin
        if (resp_fire) begin
          inflight_q <= 1'b0;
          drop_q     <= 1'b0;
        end else if (accept) begin
          inflight_q <= 1'b1;
        end
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
        if (push && !pop)      cnt_q <= cnt_q + 1'b1;
        else if (!push && pop) cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_q] <= ic_resp_data;
      q_pc[wr_q]    <= fetch_pc_q;
      q_tk[wr_q]    <= pred_tk;
      q_tgt[wr_q]   <= pred_tk ? pred_tgt : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (bp_we) begin
      if (bp_taken && bht_q[wr_idx] != 2'b11)
        bht_q[wr_idx] <= bht_q[wr_idx] + 2'b01;
      else if (!bp_taken && bht_q[wr_idx] != 2'b00)
        bht_q[wr_idx] <= bht_q[wr_idx] - 2'b01;
    end
  end

  assign out_valid       = cnt_q != '0;
  assign out_instr       = out_valid ? q_instr[rd_q] : 32'd0;
  assign out_pc          = out_valid ? q_pc[rd_q] : 32'd0;
  assign out_pc_p4       = out_valid ? q_pc[rd_q] + 32'd4 : 32'd0;
  assign out_pred_taken  = out_valid ? q_tk[rd_q] : 1'b0;
  assign out_pred_target = out_valid ? q_tgt[rd_q] : 32'd0;
endmodule

// File: tb/tb_fetch_buffered.sv
// tb/tb_fetch_buffered.sv - directed plus random stimulus against a queue-based fetch model
module tb_fetch_buffered;
  localparam int FQ_DEPTH = 4;

  logic        clk, rst_n;
  logic        redirect, ic_req_valid, ic_req_ready, ic_resp_valid;
  logic [31:0] redirect_pc, ic_req_addr, ic_resp_data;
  logic        bp_we, bp_taken, out_valid, out_ready, out_pred_taken;
  logic [31:0] bp_w_pc, out_instr, out_pc, out_pc_p4, out_pred_target;

  fetch_buffered #(.RESET_PC(32'h0), .FQ_DEPTH(FQ_DEPTH), .BHT_ENTRIES(256)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .bp_we(bp_we), .bp_w_pc(bp_w_pc), .bp_taken(bp_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_p4(out_pc_p4), .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        tk;
    logic [31:0] tgt;
  } ent_t;

  int          checks = 0;
  int          failures = 0;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_inflight, m_drop;
  int          bht [256];
  logic [31:0] mem [64];
  logic        pend;
  logic [31:0] pend_addr;
  int          pcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [20:0] o;
    o = off[20:0];
    return {o[20], o[10:1], o[11], o[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_beq(input int off);
    logic [12:0] b;
    b = off[12:0];
    return {b[12], b[10:5], 5'd0, 5'd0, 3'b000, b[4:1], b[11], 7'b1100011};
  endfunction

  // Offsets rebuilt from bit weights, sign bit carrying its negative weight
  function automatic int jal_off(input logic [31:0] w);
    return int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096 - int'(w[31]) * 1048576;
  endfunction

  function automatic int br_off(input logic [31:0] w);
    return int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - int'(w[31]) * 4096;
  endfunction

  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rdy, input logic ordy,
                       input logic bwe, input logic [31:0] bpc, input logic btk,
                       input int lat, input logic spur);
    logic e_rv, acc, resp, pop, tk;
    logic [31:0] w, pc, tgt, acc_addr, e_p4;
    ent_t h;
    redirect      = rd;
    redirect_pc   = rpc;
    ic_req_ready  = rdy;
    out_ready     = ordy;
    bp_we         = bwe;
    bp_w_pc       = bpc;
    bp_taken      = btk;
    ic_resp_valid = (pend && pcnt == 0) || (spur && !pend);
    ic_resp_data  = pend ? mem[pend_addr[7:2]] : $urandom;
    #1;
    e_rv = !m_inflight && (m_q.size() < FQ_DEPTH) && !rd;
    h    = (m_q.size() != 0) ? m_q[0] : '0;
    e_p4 = (m_q.size() != 0) ? h.pc + 32'd4 : 32'd0;
    chk("req_valid", {31'd0, ic_req_valid}, {31'd0, e_rv});
    chk("req_addr", ic_req_addr, m_pc);
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_q.size() != 0});
    chk("out_instr", out_instr, h.instr);
    chk("out_pc", out_pc, h.pc);
    chk("out_pc_p4", out_pc_p4, e_p4);
    chk("out_pred_taken", {31'd0, out_pred_taken}, {31'd0, h.tk});
    chk("out_pred_target", out_pred_target, h.tgt);
    @(posedge clk);
    acc      = e_rv && rdy;
    acc_addr = m_pc;
    resp     = ic_resp_valid && m_inflight;
    pop      = (m_q.size() != 0) && ordy;
    if (rd) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (resp) begin
        m_inflight = 1'b0;
        m_drop     = 1'b0;
      end else if (m_inflight) begin
        m_drop = 1'b1;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (resp) begin
        if (!m_drop) begin
          w   = ic_resp_data;
          pc  = m_pc;
          tk  = 1'b0;
          tgt = 32'd0;
          if (w[6:0] == 7'b1101111) begin
            tk  = 1'b1;
            tgt = pc + 32'(jal_off(w));
          end else if (w[6:0] == 7'b1100011 && bht[pc[9:2]] >= 2) begin
            tk  = 1'b1;
            tgt = pc + 32'(br_off(w));
          end
          m_q.push_back('{instr: w, pc: pc, tk: tk, tgt: tgt});
          m_pc = tk ? tgt : pc + 32'd4;
        end
        m_inflight = 1'b0;
        m_drop     = 1'b0;
      end
      if (acc) m_inflight = 1'b1;
    end
    if (bwe) begin
      if (btk) bht[bpc[9:2]] = (bht[bpc[9:2]] < 3) ? bht[bpc[9:2]] + 1 : 3;
      else     bht[bpc[9:2]] = (bht[bpc[9:2]] > 0) ? bht[bpc[9:2]] - 1 : 0;
    end
    if (pend) begin
      if (pcnt == 0) pend = 1'b0;
      else pcnt--;
    end
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pcnt      = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy, input logic ordy, input int lat);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, rdy, ordy, 1'b0, 32'd0, 1'b0, lat, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; ic_req_ready = 1'b0;
    ic_resp_valid = 1'b0; ic_resp_data = '0; bp_we = 1'b0; bp_w_pc = '0;
    bp_taken = 1'b0; out_ready = 1'b0;
    m_pc = 32'h0; m_inflight = 1'b0; m_drop = 1'b0; pend = 1'b0; pend_addr = '0; pcnt = 0;
    for (int i = 0; i < 256; i++) bht[i] = 1;
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 3))
        0: mem[i] = 32'h0000_0013;
        1: mem[i] = enc_jal((int'($urandom_range(0, 32)) - 16) * 4);
        2: mem[i] = enc_beq((int'($urandom_range(0, 32)) - 16) * 4);
        default: mem[i] = $urandom;
      endcase
    end
    for (int i = 0; i < 20; i++) mem[i] = 32'h0000_0013;
    mem[4]  = 32'h0100_006F;
    mem[16] = 32'h0000_0463;

    repeat (2) @(negedge clk);
    chk("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
    chk("rst_req_addr", ic_req_addr, 32'h0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    rst_n = 1'b1;

    run(30, 1'b1, 1'b1, 1);
    run(15, 1'b1, 1'b0, 1);
    run(12, 1'b1, 1'b1, 2);
    run(2, 1'b1, 1'b1, 3);
    cycle(1'b1, 32'h0000_0103, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1, 1'b0);
    run(10, 1'b1, 1'b1, 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1, 1'b0);
    cycle(1'b1, 32'h0000_0040, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1, 1'b0);
    run(8, 1'b1, 1'b1, 1);
    run(10, 1'b0, 1'b1, 1);
    cycle(1'b1, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1, 1'b0);
    run(3, 1'b0, 1'b1, 1);
    run(6, 1'b1, 1'b1, 1);

    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 19) == 0, $urandom_range(0, 255),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
            $urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 1) == 1,
            $urandom_range(1, 3), $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
